// File: rtl/alu_defs.sv
// Shared ALU definitions: word width and alusel opcode map used by every block
// that drives or shares the combinational ALU.
package alu_defs;

  localparam int WORD_WIDTH = 32;

  typedef logic [3:0] alusel_t;

  // Codes not listed here are undefined; the ALU answers them with res = 0, zero = 1.
  localparam alusel_t ALUSEL_ADD  = 4'h0;
  localparam alusel_t ALUSEL_SUB  = 4'h1;
  localparam alusel_t ALUSEL_AND  = 4'h2;
  localparam alusel_t ALUSEL_OR   = 4'h3;
  localparam alusel_t ALUSEL_XOR  = 4'h4;
  localparam alusel_t ALUSEL_SLL  = 4'h6;
  localparam alusel_t ALUSEL_SRL  = 4'h7;
  localparam alusel_t ALUSEL_SRA  = 4'h8;
  localparam alusel_t ALUSEL_SLT  = 4'h9;
  localparam alusel_t ALUSEL_SLTU = 4'hA;

  localparam alusel_t ALUSEL_DEFAULT = ALUSEL_ADD;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 (mod N) for the first
// asserted request and returns a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic w_found;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    // Offsets are scanned in priority order; k is compared rather than used as
    // an index so every select stays constant after unrolling.
    for (int off = 1; off <= N; off++) begin
      for (int k = 0; k < N; k++) begin
        if (en && !w_found && req[k] && (k == ((int'(ptr) + off) % N))) begin
          gnt[k]  = 1'b1;
          idx     = IDX_W'(k);
          w_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between NUM_REQ requesters through a 2-stage
// pipeline (command, result). Define ALU_ARB_PRIO0_EN to give requester 0 absolute priority.
module alu_share_arb
  import alu_defs::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_opa,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_opb,
  input  logic [NUM_REQ*4-1:0]          req_sel,
  output logic [WORD_WIDTH-1:0]         alu_opA,
  output logic [WORD_WIDTH-1:0]         alu_opB,
  output logic [3:0]                    alu_sel,
  input  logic [WORD_WIDTH-1:0]         alu_res,
  input  logic                          alu_zero,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [WORD_WIDTH-1:0]         rsp_res,
  output logic                          rsp_zero
);

  logic [ID_W-1:0]       r_ptr;
  logic                  r_cmd_vld_p0;
  logic [ID_W-1:0]       r_cmd_id_p0;
  logic [WORD_WIDTH-1:0] r_cmd_a_p0;
  logic [WORD_WIDTH-1:0] r_cmd_b_p0;
  alusel_t               r_cmd_sel_p0;
  logic                  r_rsp_vld_p1;
  logic [ID_W-1:0]       r_rsp_id_p1;
  logic [WORD_WIDTH-1:0] r_rsp_res_p1;
  logic                  r_rsp_zero_p1;

  logic                  w_stall;
  logic                  w_accept;
  logic                  w_ptr_upd;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [ID_W-1:0]       w_win_idx;
  logic [NUM_REQ-1:0]    w_rr_req;
  logic                  w_rr_en;
  logic [NUM_REQ-1:0]    w_rr_gnt;
  logic [ID_W-1:0]       w_rr_idx;
  logic [WORD_WIDTH-1:0] w_win_a;
  logic [WORD_WIDTH-1:0] w_win_b;
  alusel_t               w_win_sel;

  assign w_stall = r_rsp_vld_p1 & ~rsp_ready;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .req (w_rr_req),
    .ptr (r_ptr),
    .en  (w_rr_en),
    .gnt (w_rr_gnt),
    .idx (w_rr_idx)
  );

`ifdef ALU_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation; the others share the pointer among themselves.
  assign w_rr_req  = {req_valid[NUM_REQ-1:1], 1'b0};
  assign w_rr_en   = ~w_stall & ~req_valid[0];
  assign w_gnt     = (~w_stall & req_valid[0]) ? NUM_REQ'(1) : w_rr_gnt;
  assign w_win_idx = req_valid[0] ? '0 : w_rr_idx;
  assign w_ptr_upd = |w_rr_gnt;
`else
  assign w_rr_req  = req_valid;
  assign w_rr_en   = ~w_stall;
  assign w_gnt     = w_rr_gnt;
  assign w_win_idx = w_rr_idx;
  assign w_ptr_upd = |w_rr_gnt;
`endif

  assign w_accept  = |w_gnt;
  assign req_ready = w_gnt;

  // One-hot mux of the winner's packed fields.
  always_comb begin
    w_win_a   = '0;
    w_win_b   = '0;
    w_win_sel = ALUSEL_DEFAULT;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win_a   = req_opa[i*WORD_WIDTH +: WORD_WIDTH];
        w_win_b   = req_opb[i*WORD_WIDTH +: WORD_WIDTH];
        w_win_sel = req_sel[i*4 +: 4];
      end
    end
  end

  // Stage p0: granted command register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ptr        <= ID_W'(NUM_REQ - 1);
      r_cmd_vld_p0 <= 1'b0;
      r_cmd_id_p0  <= '0;
      r_cmd_a_p0   <= '0;
      r_cmd_b_p0   <= '0;
      r_cmd_sel_p0 <= ALUSEL_DEFAULT;
    end else begin
      if (w_ptr_upd) begin
        r_ptr <= w_win_idx;
      end
      if (!w_stall) begin
        r_cmd_vld_p0 <= w_accept;
        if (w_accept) begin
          r_cmd_id_p0  <= w_win_idx;
          r_cmd_a_p0   <= w_win_a;
          r_cmd_b_p0   <= w_win_b;
          r_cmd_sel_p0 <= w_win_sel;
        end
      end
    end
  end

  assign alu_opA = r_cmd_a_p0;
  assign alu_opB = r_cmd_b_p0;
  assign alu_sel = r_cmd_vld_p0 ? r_cmd_sel_p0 : ALUSEL_DEFAULT;

  // Stage p1: ALU result register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rsp_vld_p1  <= 1'b0;
      r_rsp_id_p1   <= '0;
      r_rsp_res_p1  <= '0;
      r_rsp_zero_p1 <= 1'b0;
    end else if (!w_stall) begin
      r_rsp_vld_p1  <= r_cmd_vld_p0;
      r_rsp_id_p1   <= r_cmd_id_p0;
      r_rsp_res_p1  <= alu_res;
      r_rsp_zero_p1 <= alu_zero;
    end
  end

  assign rsp_valid = r_rsp_vld_p1;
  assign rsp_id    = r_rsp_id_p1;
  assign rsp_res   = r_rsp_res_p1;
  assign rsp_zero  = r_rsp_zero_p1;

endmodule
